des_key_schedule: RTL and testbench

//  Sequential DES subkey generator feeding the round datapath in front of the S-box stage.

---
 rtl/des_key_schedule.sv | 123 ++++++++++++
 tb/tb_des_key_schedule.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1 on key accept, then per-round C/D rotations with PC-2 on the output.
// Latency: first subkey valid the cycle after key accept, then one subkey per handshake (zero-bubble).
// Backpressure: subkey_valid & !subkey_ready freezes all state; key_ready is low while a stream runs.
module des_key_schedule #(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic        key_decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_num,
    output logic        subkey_last,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        parity_err
);

    typedef enum logic {IDLE, RUN} state_t;

    // Permuted choice tables in FIPS bit numbering (bit 1 = MSB).
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // Bit n-1 set when round n shifts by two (rounds 1, 2, 9 and 16 shift by one).
    localparam logic [15:0] SHIFT2_MASK = 16'h7EFC;

    state_t      state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [4:0]  round_q;
    logic        mode_q;

    logic [55:0] pc1_key;
    logic [55:0] cd;
    logic [7:0]  byte_even;
    logic        accept;
    logic        handshake;
    logic [3:0]  dec_idx;
    logic [3:0]  shift_idx;
    logic        shift_two;
    logic        running;

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[55-gi] = key[64-PC1_TBL[gi]];
        end
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign subkey[47-gi] = cd[56-PC2_TBL[gi]];
        end
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign byte_even[gi] = ~^key[8*gi+7:8*gi];
        end
    endgenerate

    assign cd        = {c_q, d_q};
    assign accept    = key_valid & key_ready;
    assign handshake = subkey_valid & subkey_ready;
    assign running   = (state == RUN);

    // Decrypt walks the schedule backwards: round r shows K(17-r) and undoes shift s[17-r].
    assign dec_idx   = 4'(5'd16 - round_q);
    assign shift_idx = mode_q ? dec_idx : round_q[3:0];
    assign shift_two = SHIFT2_MASK[shift_idx];

    assign subkey_num  = running ? (mode_q ? dec_idx : 4'(round_q - 5'd1)) : 4'd0;
    assign subkey_last = running & (round_q == 5'd16);

    // Key schedule FSM: load PC-1 on accept, advance C/D one round per subkey handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            c_q          <= '0;
            d_q          <= '0;
            round_q      <= '0;
            mode_q       <= 1'b0;
            key_ready    <= 1'b1;
            subkey_valid <= 1'b0;
            parity_err   <= 1'b0;
        end else if (accept) begin
            // Decrypt starts from C0D0, which equals C16D16 after a full 28-bit rotation.
            c_q          <= key_decrypt ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
            d_q          <= key_decrypt ? pc1_key[27:0]  : rotl(pc1_key[27:0], 1'b0);
            round_q      <= 5'd1;
            mode_q       <= key_decrypt;
            state        <= RUN;
            key_ready    <= 1'b0;
            subkey_valid <= 1'b1;
            parity_err   <= CHECK_PARITY & (|byte_even);
        end else if (handshake) begin
            if (round_q == 5'd16) begin
                state        <= IDLE;
                key_ready    <= 1'b1;
                subkey_valid <= 1'b0;
            end else begin
                c_q     <= mode_q ? rotr(c_q, shift_two) : rotl(c_q, shift_two);
                d_q     <= mode_q ? rotr(d_q, shift_two) : rotl(d_q, shift_two);
                round_q <= round_q + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, random keys with stalls, back-to-back keys, mid-stream reset.
// Reference model builds all 16 subkeys from FIPS bit arrays with cumulative rotation offsets.
// Parity-checking and non-checking instances share the same stimulus.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key;
    logic        key_decrypt;
    logic        key_valid;
    logic        subkey_ready;

    logic        key_ready,   key_ready_np;
    logic [47:0] subkey,      subkey_np;
    logic [3:0]  subkey_num,  subkey_num_np;
    logic        subkey_last, subkey_last_np;
    logic        subkey_valid, subkey_valid_np;
    logic        parity_err,  parity_err_np;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_decrypt(key_decrypt),
        .key_valid(key_valid), .key_ready(key_ready), .subkey(subkey),
        .subkey_num(subkey_num), .subkey_last(subkey_last),
        .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .parity_err(parity_err)
    );

    des_key_schedule #(.CHECK_PARITY(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .key(key), .key_decrypt(key_decrypt),
        .key_valid(key_valid), .key_ready(key_ready_np), .subkey(subkey_np),
        .subkey_num(subkey_num_np), .subkey_last(subkey_last_np),
        .subkey_valid(subkey_valid_np), .subkey_ready(subkey_ready),
        .parity_err(parity_err_np)
    );

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_ks [16];   // K1..K16 for the key under test
    logic [47:0] got_sk [16];   // subkeys in emission order from the last collect
    logic [47:0] enc_seq [16];

    typedef struct {
        logic [63:0] k;
        logic        dec;
        logic [47:0] first_sk;
        logic [3:0]  first_num;
        logic [47:0] last_sk;
        logic        par;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard schedule: Cn/Dn are C0/D0 rotated left by the running sum of shifts.
    task automatic ref_fill(input logic [63:0] k);
        logic        kb [65];
        logic        c0 [28];
        logic        d0 [28];
        logic [63:0] t;
        logic [47:0] ks;
        int          tot;
        int          p;
        t = k;
        kb[0] = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            kb[i] = t[63];
            t = t << 1;
        end
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1[i]];
            d0[i] = kb[PC1[28+i]];
        end
        tot = 0;
        for (int n = 0; n < 16; n++) begin
            tot += SHIFTS[n];
            ks = '0;
            for (int j = 0; j < 48; j++) begin
                p = PC2[j];
                if (p <= 28) ks = (ks << 1) | {47'd0, c0[(p - 1 + tot) % 28]};
                else         ks = (ks << 1) | {47'd0, d0[(p - 29 + tot) % 28]};
            end
            exp_ks[n] = ks;
        end
    endtask

    function automatic logic ref_parity(input logic [63:0] k);
        logic [63:0] t;
        logic        even;
        t = k;
        even = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (($countones(t[7:0]) % 2) == 0) even = 1'b1;
            t = t >> 8;
        end
        return even;
    endfunction

    // Present a key, wait (bounded) for acceptance, leave the bench at the first subkey cycle.
    task automatic send_key(input logic [63:0] k, input logic dec);
        int w;
        key = k;
        key_decrypt = dec;
        key_valid = 1'b1;
        w = 0;
        while (!key_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!key_ready) check("key_ready_timeout", 64'(key_ready), 64'd1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_decrypt = $urandom_range(1);
        check("parity_err", 64'(parity_err), 64'(ref_parity(k)));
        check("parity_err_np", 64'(parity_err_np), 64'd0);
    endtask

    // Take n_take subkeys with random stalls; compare against the model and check hold during stalls.
    task automatic collect(input logic dec, input int stall_pct, input int n_take);
        int          got;
        int          cyc;
        int          idx;
        logic        held;
        logic [47:0] h_sk;
        logic [3:0]  h_num;
        logic        h_last;
        got = 0;
        cyc = 0;
        held = 1'b0;
        while (got < n_take && cyc < 2000) begin
            check("subkey_valid", 64'(subkey_valid), 64'd1);
            check("key_ready_run", 64'(key_ready), 64'd0);
            if (subkey_valid) begin
                if (held) begin
                    check("stall_subkey", 64'(subkey), 64'(h_sk));
                    check("stall_num", 64'(subkey_num), 64'(h_num));
                    check("stall_last", 64'(subkey_last), 64'(h_last));
                end
                subkey_ready = ($urandom_range(99) >= stall_pct);
                if (subkey_ready) begin
                    idx = dec ? 15 - got : got;
                    check("subkey", 64'(subkey), 64'(exp_ks[idx]));
                    check("subkey_np", 64'(subkey_np), 64'(exp_ks[idx]));
                    check("subkey_num", 64'(subkey_num), 64'(idx));
                    check("subkey_last", 64'(subkey_last), 64'(got == 15));
                    got_sk[got] = subkey;
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_sk = subkey;
                    h_num = subkey_num;
                    h_last = subkey_last;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < n_take) check("stream_timeout", 64'(got), 64'(n_take));
        if (n_take == 16) begin
            subkey_ready = 1'b0;
            check("valid_after_last", 64'(subkey_valid), 64'd0);
            check("ready_after_last", 64'(key_ready), 64'd1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k1;
        logic [63:0] k2;
        logic        d;

        tbl[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 1'b0};
        tbl[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 1'b0};
        tbl[2] = '{64'h0000000000000000, 1'b0, 48'h000000000000, 4'd0,  48'h000000000000, 1'b1};
        tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 4'd15, 48'hFFFFFFFFFFFF, 1'b1};
        tbl[4] = '{64'h0101010101010101, 1'b0, 48'h000000000000, 4'd0,  48'h000000000000, 1'b0};
        tbl[5] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 4'd15, 48'hFFFFFFFFFFFF, 1'b0};

        rst_n = 1'b0;
        key = '0;
        key_decrypt = 1'b0;
        key_valid = 1'b0;
        subkey_ready = 1'b0;
        #12;
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_subkey_valid", 64'(subkey_valid), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_subkey_num", 64'(subkey_num), 64'd0);
        check("rst_subkey_last", 64'(subkey_last), 64'd0);
        check("rst_parity_err", 64'(parity_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer table, full-rate streaming.
        for (int t = 0; t < 6; t++) begin
            ref_fill(tbl[t].k);
            send_key(tbl[t].k, tbl[t].dec);
            check("tbl_parity", 64'(parity_err), 64'(tbl[t].par));
            check("tbl_first_subkey", 64'(subkey), 64'(tbl[t].first_sk));
            check("tbl_first_num", 64'(subkey_num), 64'(tbl[t].first_num));
            collect(tbl[t].dec, 0, 16);
            check("tbl_last_subkey", 64'(got_sk[15]), 64'(tbl[t].last_sk));
            if (t == 0) for (int j = 0; j < 16; j++) enc_seq[j] = got_sk[j];
            if (t == 1) for (int j = 0; j < 16; j++)
                check("dec_reverse", 64'(got_sk[j]), 64'(enc_seq[15-j]));
            @(posedge clk); #1;
        end

        // Random keys and directions with random consumer stalls.
        for (int n = 0; n < 200; n++) begin
            k1 = {$urandom, $urandom};
            d = $urandom_range(1);
            ref_fill(k1);
            send_key(k1, d);
            collect(d, 40, 16);
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Back-to-back: second key held valid throughout the first stream, mode flipped mid-stream.
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        ref_fill(k1);
        send_key(k1, 1'b0);
        key = k2;
        key_decrypt = 1'b1;
        key_valid = 1'b1;
        collect(1'b0, 0, 16);
        ref_fill(k2);
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("b2b_parity", 64'(parity_err), 64'(ref_parity(k2)));
        collect(1'b1, 0, 16);

        // Reset mid-stream after the fifth subkey, then a fresh key.
        @(posedge clk); #1;
        k1 = {$urandom, $urandom};
        ref_fill(k1);
        send_key(k1, 1'b0);
        collect(1'b0, 0, 5);
        subkey_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_subkey_valid", 64'(subkey_valid), 64'd0);
        check("arst_key_ready", 64'(key_ready), 64'd1);
        check("arst_subkey", 64'(subkey), 64'd0);
        check("arst_parity_err", 64'(parity_err), 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 64'(subkey_valid), 64'd0);
        k2 = {$urandom, $urandom};
        ref_fill(k2);
        send_key(k2, 1'b0);
        check("post_rst_k1", 64'(subkey), 64'(exp_ks[0]));
        collect(1'b0, 0, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
